// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, operand forwarding, cache-miss freeze.
// Latency: stalls, flushes and forwarding are combinational; the miss FSM and counters update on clk_i.
// Backpressure: a data-cache miss freezes all four pipeline stages until refill completes.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   rd_addr*_d_i / rd_addr*_e_i        source registers in Decode / Execute
//   wr_addr_{e,m,w}_i, reg_wr_en_{m,w}_i  destinations and write enables downstream
//   load_flag_e_i, pc_src_e_i          load in Execute, taken branch/jump in Execute
//   cache_miss_i, cache_ready_i        miss pulse and refill-complete
//   stall_*_o, flush_*_o               pipeline register holds and bubbles
//   forward_{a,b}_e_o                  00 regfile, 10 Memory result, 01 Writeback result
//   miss_busy_o, miss_err_o            miss FSM active, sticky miss timeout
//   stall_cnt_o, flush_cnt_o           wrapping performance counters
module hazard_ctrl #(
    parameter int MISS_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rd_addr1_d_i,
    input  logic [4:0]       rd_addr2_d_i,
    input  logic [4:0]       rd_addr1_e_i,
    input  logic [4:0]       rd_addr2_e_i,
    input  logic [4:0]       wr_addr_e_i,
    input  logic [4:0]       wr_addr_m_i,
    input  logic [4:0]       wr_addr_w_i,
    input  logic             reg_wr_en_m_i,
    input  logic             reg_wr_en_w_i,
    input  logic             load_flag_e_i,
    input  logic             pc_src_e_i,
    input  logic             cache_miss_i,
    input  logic             cache_ready_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             stall_m_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [1:0]       forward_a_e_o,
    output logic [1:0]       forward_b_e_o,
    output logic             miss_busy_o,
    output logic             miss_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MISS   = 2'd1,
        RESUME = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT  = 9'(MISS_TIMEOUT);
    localparam logic [8:0] WAIT_MAX = 9'h1FF;

    state_t           state_q;
    state_t           state_nxt;
    logic             miss_stall;
    logic             load_use;
    logic [8:0]       wait_q;
    logic             err_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Next-state logic. miss_stall also covers the IDLE cycle in which the
    // miss first appears, so the pipeline freezes before the state updates.
    always_comb begin
        state_nxt  = state_q;
        miss_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (cache_miss_i) begin
                    state_nxt  = MISS;
                    miss_stall = 1'b1;
                end
            end
            MISS: begin
                miss_stall = 1'b1;
                if (cache_ready_i) begin
                    state_nxt = RESUME;
                end
            end
            RESUME: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign load_use = load_flag_e_i && (wr_addr_e_i != 5'd0) &&
                      ((wr_addr_e_i == rd_addr1_d_i) || (wr_addr_e_i == rd_addr2_d_i));

    // Priority: reset, then miss freeze, then taken branch (the load-use
    // victim is being squashed anyway), then load-use bubble.
    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        stall_m_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        if (!rst_i) begin
            if (miss_stall) begin
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
                stall_e_o = 1'b1;
                stall_m_o = 1'b1;
            end else if (pc_src_e_i) begin
                flush_d_o = 1'b1;
                flush_e_o = 1'b1;
            end else if (load_use) begin
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
                flush_e_o = 1'b1;
            end
        end
    end

    // Memory stage holds the younger result, so it takes precedence.
    always_comb begin
        forward_a_e_o = 2'b00;
        if (reg_wr_en_m_i && (wr_addr_m_i != 5'd0) && (wr_addr_m_i == rd_addr1_e_i)) begin
            forward_a_e_o = 2'b10;
        end else if (reg_wr_en_w_i && (wr_addr_w_i != 5'd0) && (wr_addr_w_i == rd_addr1_e_i)) begin
            forward_a_e_o = 2'b01;
        end
    end

    always_comb begin
        forward_b_e_o = 2'b00;
        if (reg_wr_en_m_i && (wr_addr_m_i != 5'd0) && (wr_addr_m_i == rd_addr2_e_i)) begin
            forward_b_e_o = 2'b10;
        end else if (reg_wr_en_w_i && (wr_addr_w_i != 5'd0) && (wr_addr_w_i == rd_addr2_e_i)) begin
            forward_b_e_o = 2'b01;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Wait counter saturates rather than wraps so a long miss cannot make
    // the timeout comparison match a second time or alias.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q <= 9'd0;
            err_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && (state_nxt == MISS)) begin
                wait_q <= 9'd0;
            end else if ((state_q == MISS) && (wait_q != WAIT_MAX)) begin
                wait_q <= wait_q + 9'd1;
                if ((wait_q + 9'd1) == TIMEOUT) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall_f_o);
            flush_cnt_q <= flush_cnt_q + CNT_W'(flush_e_o);
        end
    end

    assign miss_busy_o = (state_q != IDLE);
    assign miss_err_o  = err_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int TO    = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       ra1d, ra2d, ra1e, ra2e, wae, wam, waw;
    logic             wem, wew, ld, pcs, miss, rdy;
    logic             stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0]       fwd_a, fwd_b;
    logic             busy, err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: miss progress tracked as flags and an elapsed count.
    bit m_in_miss, m_resume, m_err;
    int m_wait, m_scnt, m_fcnt;

    hazard_ctrl #(.MISS_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_addr1_d_i(ra1d), .rd_addr2_d_i(ra2d),
        .rd_addr1_e_i(ra1e), .rd_addr2_e_i(ra2e),
        .wr_addr_e_i(wae), .wr_addr_m_i(wam), .wr_addr_w_i(waw),
        .reg_wr_en_m_i(wem), .reg_wr_en_w_i(wew),
        .load_flag_e_i(ld), .pc_src_e_i(pcs),
        .cache_miss_i(miss), .cache_ready_i(rdy),
        .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e), .stall_m_o(stall_m),
        .flush_d_o(flush_d), .flush_e_o(flush_e),
        .forward_a_e_o(fwd_a), .forward_b_e_o(fwd_b),
        .miss_busy_o(busy), .miss_err_o(err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input bit we_m, input int am, input bit we_w, input int aw, input int src);
        if (we_m && am != 0 && am == src) return 2;
        if (we_w && aw != 0 && aw == src) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_in_miss = 0; m_resume = 0; m_err = 0;
        m_wait = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic clr();
        ra1d = 0; ra2d = 0; ra1e = 0; ra2e = 0; wae = 0; wam = 0; waw = 0;
        wem = 0; wew = 0; ld = 0; pcs = 0; miss = 0; rdy = 0;
    endtask

    // Called at a falling edge with inputs already applied: checks every
    // output against the model, then advances one clock.
    task automatic step();
        bit mn, lu;
        bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe;
        #1;
        mn = !rst && (m_in_miss || (!m_resume && miss));
        lu = ld && (wae != 0) && (wae == ra1d || wae == ra2d);
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe} = '0;
        if (!rst) begin
            if (mn) begin
                e_sf = 1; e_sd = 1; e_se = 1; e_sm = 1;
            end else if (pcs) begin
                e_fd = 1; e_fe = 1;
            end else if (lu) begin
                e_sf = 1; e_sd = 1; e_fe = 1;
            end
        end
        check("stall_f", 32'(stall_f), 32'(e_sf));
        check("stall_d", 32'(stall_d), 32'(e_sd));
        check("stall_e", 32'(stall_e), 32'(e_se));
        check("stall_m", 32'(stall_m), 32'(e_sm));
        check("flush_d", 32'(flush_d), 32'(e_fd));
        check("flush_e", 32'(flush_e), 32'(e_fe));
        check("fwd_a", 32'(fwd_a), 32'(ref_fwd(wem, int'(wam), wew, int'(waw), int'(ra1e))));
        check("fwd_b", 32'(fwd_b), 32'(ref_fwd(wem, int'(wam), wew, int'(waw), int'(ra2e))));
        check("busy", 32'(busy), 32'(m_in_miss || m_resume));
        check("err", 32'(err), 32'(m_err));
        check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        check("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_scnt = (m_scnt + int'(e_sf)) % 256;
            m_fcnt = (m_fcnt + int'(e_fe)) % 256;
            if (m_in_miss) begin
                m_wait++;
                if (m_wait >= TO) m_err = 1;
                if (rdy) begin
                    m_in_miss = 0;
                    m_resume  = 1;
                end
            end else if (m_resume) begin
                m_resume = 0;
            end else if (miss) begin
                m_in_miss = 1;
                m_wait    = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int s0;
        clr();
        rst = 1;
        model_reset();
        @(negedge clk);
        step();
        rst = 0;
        @(negedge clk);

        // Load x5 in Execute, Decode reads x5.
        ld = 1; wae = 5; ra1d = 5;
        step();
        clr();
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        check("lu_flush_cnt", 32'(flush_cnt), 32'd1);
        step();

        // Taken branch with a simultaneous load-use on x5.
        pcs = 1; ld = 1; wae = 5; ra2d = 5;
        #1;
        check("br_stall_f", 32'(stall_f), 32'd0);
        check("br_flush_d", 32'(flush_d), 32'd1);
        step();
        clr();
        check("br_flush_cnt", 32'(flush_cnt), 32'd2);
        check("br_stall_cnt", 32'(stall_cnt), 32'd1);

        // Forwarding: both stages write x3, Memory wins; then x0 never forwards.
        wem = 1; wam = 3; wew = 1; waw = 3; ra1e = 3; ra2e = 3;
        #1;
        check("fwd_a_mem", 32'(fwd_a), 32'd2);
        check("fwd_b_mem", 32'(fwd_b), 32'd2);
        step();
        wem = 0;
        #1;
        check("fwd_a_wb", 32'(fwd_a), 32'd1);
        step();
        wem = 1; wam = 0; waw = 0; ra1e = 0; ra2e = 0;
        #1;
        check("fwd_a_x0", 32'(fwd_a), 32'd0);
        check("fwd_b_x0", 32'(fwd_b), 32'd0);
        step();
        clr();

        // Miss pulse, ready four cycles later: five stall cycles, one RESUME.
        s0 = m_scnt;
        miss = 1;
        step();
        miss = 0;
        repeat (3) step();
        rdy = 1;
        step();
        rdy = 0;
        check("miss_resume_busy", 32'(busy), 32'd1);
        step();
        check("miss_idle_busy", 32'(busy), 32'd0);
        check("miss_stall_cnt", 32'(stall_cnt), 32'((s0 + 5) % 256));
        step();

        // Timeout after TO miss cycles; sticky past ready.
        miss = 1;
        step();
        miss = 0;
        repeat (TO - 1) step();
        check("err_before_to", 32'(err), 32'd0);
        step();
        check("err_at_to", 32'(err), 32'd1);
        rdy = 1;
        step();
        rdy = 0;
        repeat (2) step();
        check("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a miss.
        miss = 1;
        step();
        miss = 0;
        repeat (2) step();
        rst = 1;
        model_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check("rst_stall_f", 32'(stall_f), 32'd0);
        @(negedge clk);
        step();
        rst = 0;
        #1;
        check("post_rst_stall", 32'(stall_m), 32'd0);
        step();

        // Randomized traffic; counters are 8 bits so they wrap along the way.
        for (int i = 0; i < 3000; i++) begin
            ra1d = 5'($urandom_range(0, 3));
            ra2d = 5'($urandom_range(0, 3));
            ra1e = 5'($urandom_range(0, 3));
            ra2e = 5'($urandom_range(0, 3));
            wae  = 5'($urandom_range(0, 3));
            wam  = 5'($urandom_range(0, 3));
            waw  = 5'($urandom_range(0, 3));
            wem  = ($urandom_range(0, 1) == 1);
            wew  = ($urandom_range(0, 1) == 1);
            ld   = ($urandom_range(0, 9) < 3);
            pcs  = ($urandom_range(0, 9) < 2);
            miss = ($urandom_range(0, 19) == 0);
            rdy  = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1;
                model_reset();
            end else begin
                rst = 0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MISS_TIMEOUT, default 255, miss-wait cycle limit before the error flag sets.
REQ-002 Parameter: CNT_W, default 32, width of the performance counters.
REQ-003 Port: clk_i  in  1  single clock, all state on its rising edge.
REQ-004 Port: rst_i  in  1  reset, asynchronous, active-high.
REQ-005 Ports: rd_addr1_d_i, rd_addr2_d_i  in  5 each  source registers of the instruction in Decode.
REQ-006 Ports: rd_addr1_e_i, rd_addr2_e_i  in  5 each  source registers of the instruction in Execute.
REQ-007 Ports: wr_addr_e_i, wr_addr_m_i, wr_addr_w_i  in  5 each  destination registers in Execute, Memory and Writeback.
REQ-008 Ports: reg_wr_en_m_i, reg_wr_en_w_i  in  1 each  register-write enables in Memory and Writeback.
REQ-009 Port: load_flag_e_i  in  1  instruction in Execute is a load.
REQ-010 Port: pc_src_e_i  in  1  branch or jump taken, resolved in Execute.
REQ-011 Port: cache_miss_i  in  1  data-memory miss pulse for the access in Memory.
REQ-012 Port: cache_ready_i  in  1  refill complete.
REQ-013 Ports: stall_f_o, stall_d_o, stall_e_o, stall_m_o  out  1 each  hold the PC and the F/D, D/E and E/M registers.
REQ-014 Ports: flush_d_o, flush_e_o  out  1 each  bubble the F/D and D/E registers; flush_e_o drives the D/E register's flush_i.
REQ-015 Ports: forward_a_e_o, forward_b_e_o  out  2 each  operand select: 00 register file, 10 Memory result, 01 Writeback result.
REQ-016 Port: miss_busy_o  out  1  FSM not in IDLE.
REQ-017 Port: miss_err_o  out  1  sticky miss-timeout flag.
REQ-018 Ports: stall_cnt_o, flush_cnt_o  out  CNT_W each  performance counters.

Function
REQ-019 FSM states SHALL be IDLE, MISS and RESUME, registered.
REQ-020 Transition IDLE->MISS SHALL occur on cache_miss_i=1.
REQ-021 Transition MISS->RESUME SHALL occur on cache_ready_i=1; otherwise the FSM SHALL stay in MISS.
REQ-022 RESUME SHALL last exactly one cycle and then return to IDLE.
REQ-023 While in MISS, stall_f_o, stall_d_o, stall_e_o and stall_m_o SHALL be 1 and both flushes SHALL be 0, overriding all other hazards.
REQ-024 In the cycle cache_miss_i first rises (state IDLE), all four stalls SHALL assert combinationally.
REQ-025 In RESUME, no stall SHALL be forced; normal hazard logic applies.
REQ-026 A 9-bit wait counter SHALL clear on entry to MISS and increment each MISS cycle.
REQ-027 When the wait counter reaches MISS_TIMEOUT, miss_err_o SHALL set and stay set until reset; the FSM SHALL remain in MISS.
REQ-028 Load-use hazard condition: load_flag_e_i=1, wr_addr_e_i!=0, and wr_addr_e_i equals rd_addr1_d_i or rd_addr2_d_i.
REQ-029 On load-use (outside a miss), the block SHALL assert stall_f_o=1, stall_d_o=1 and flush_e_o=1 for one cycle.
REQ-030 When pc_src_e_i=1 (outside a miss), the block SHALL assert flush_d_o=1 and flush_e_o=1.
REQ-031 If pc_src_e_i and load-use coincide, the branch SHALL win: flushes asserted, stall_f_o and stall_d_o SHALL be 0.
REQ-032 forward_a_e_o SHALL be 10 if reg_wr_en_m_i=1, wr_addr_m_i!=0 and wr_addr_m_i=rd_addr1_e_i.
REQ-033 Otherwise forward_a_e_o SHALL be 01 if the same holds for Writeback; otherwise 00.
REQ-034 forward_b_e_o SHALL follow REQ-032 and REQ-033 using rd_addr2_e_i.
REQ-035 Forwarding SHALL be purely combinational and SHALL stay valid during stalls.
REQ-036 stall_cnt_o SHALL increment in every cycle in which stall_f_o=1, wrapping modulo 2^CNT_W.
REQ-037 flush_cnt_o SHALL increment in every cycle in which flush_e_o=1, wrapping modulo 2^CNT_W.
REQ-038 All stall and flush outputs SHALL be 0 while rst_i=1.

Reset
REQ-039 rst_i=1 SHALL asynchronously force state IDLE, wait counter 0, miss_err_o=0, stall_cnt_o=0 and flush_cnt_o=0.
REQ-040 Reset asserted during MISS SHALL abort the miss immediately; the first post-reset cycle SHALL be IDLE with no stalls.

Verification
REQ-041 Scenario: load x5 in Execute, Decode reads x5 -> stall_f_o=stall_d_o=flush_e_o=1 for 1 cycle, stall_cnt_o +1, flush_cnt_o +1.
REQ-042 Scenario: pc_src_e_i=1 together with a load-use on x5 -> flush_d_o=flush_e_o=1, stall_f_o=0.
REQ-043 Scenario: Memory writes x3, Writeback writes x3, Execute reads x3 on both operands -> forward_a_e_o=forward_b_e_o=10; with a write to x0 instead -> 00.
REQ-044 Scenario: cache_miss_i pulse, cache_ready_i 4 cycles later -> all stalls high 5 cycles, then RESUME for 1 cycle, then IDLE; stall_cnt_o +5.
REQ-045 Scenario: MISS_TIMEOUT=8, cache_ready_i held low -> miss_err_o=1 after 8 MISS cycles; stays 1 after the later ready; cleared only by rst_i.
REQ-046 Scenario: rst_i pulsed mid-MISS -> miss_busy_o=0 and all counters 0 asynchronously.
